riscv_pipe_regs: RTL and testbench
==================================

// Module: riscv_pipe_regs
// PURPOSE
// - Parametrised inter-stage register chain for the pipelined RISC-V core, successor to the single-cycle wiring bundle.
// - Carries pc + payload (decoded control/data) from fetch through NSTG pipeline boundaries (default IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Per-boundary stall and flush, valid bits, automatic bubble insertion; hazard/jump controllers drive stall/flush.
// PARAMETERS
// - NSTG       4    number of pipeline boundaries (>=2); index 0 = IF/ID, NSTG-1 = MEM/WB
// - XLEN       32   pc width
// - PAYLOAD_W  64   payload width per boundary (uniform; unused bits tied off by consumer)
// PORTS
// - clk         in   1               core clock, all state on rising edge
// - reset       in   1               asynchronous, active-low reset
// - in_valid    in   1               fetch stage presents a valid instruction
// - in_pc       in   XLEN            pc of fetched instruction
// - in_payload  in   PAYLOAD_W       fetch payload (instruction word etc.)
// - in_ready    out  1               boundary 0 accepts this cycle (= !hold[0])
// - stall       in   NSTG            stall[i]: boundary i must keep its content
// - flush       in   NSTG            flush[i]: boundary i content invalidated
// - st_valid    out  NSTG            valid bit per boundary
// - st_pc       out  NSTG*XLEN       pc per boundary, boundary i at [i*XLEN +: XLEN]
// - st_payload  out  NSTG*PAYLOAD_W  payload per boundary, same packing
// - cycle_cnt   out  32              perf: cycles since reset (see CONFIGURATION)
// - retire_cnt  out  32              perf: valid entries leaving boundary NSTG-1
// - bubble_cnt  out  32              perf: cycles with st_valid[NSTG-1]==0
// BEHAVIOUR
// - Reset (reset==0, async): st_valid=0, st_pc=0, st_payload=0, all counters 0. Release synchronous to clk.
// - hold[i] = OR(stall[j], j>=i): a downstream stall freezes every upstream boundary.
// - Per boundary i, each rising edge, priority order:
//   1. flush[i]=1            -> st_valid[i]<=0; pc/payload unchanged (flush beats stall).
//   2. hold[i]=1             -> all fields held.
//   3. i>0 && hold[i-1]=1    -> bubble: st_valid[i]<=0, pc/payload unchanged.
//   4. else                  -> load from boundary i-1 (i=0: in_valid/in_pc/in_payload).
// - Latency: accepted instruction reaches boundary NSTG-1 after NSTG edges with no stall/flush.
// - Handshake: fetch must hold in_* stable while in_ready=0; in_valid is ignored when in_ready=0.
// - Flush of a boundary that is also the load source: downstream loads pre-flush content on the same edge.
// - Flush with stall on the same boundary: valid cleared, boundary still held (no load).
// - Simultaneous stall[i] and flush[i+1]: boundary i held, i+1 gets bubble (valid 0).
// - Invalid entries move like valid ones; consumers gate side effects on st_valid.
// - Outputs are registered; no combinational path from stall/flush to st_* (in_ready is combinational from stall).
// CONFIGURATION
// - Macro RISCV_PIPE_PERF_CNT_EN:
//   - defined: cycle_cnt increments every cycle out of reset; retire_cnt increments when st_valid[NSTG-1]=1 and !hold[NSTG-1]
//     and !flush[NSTG-1]; bubble_cnt increments when st_valid[NSTG-1]=0. All saturate at 32'hFFFF_FFFF.
//   - undefined: counter logic absent; the three ports remain and are driven constant 0.
// TESTING
// - Reset mid-stream: 3 valid instrs in flight, reset low 1 cycle -> st_valid=4'b0000, all st_pc=0 immediately (async).
// - Straight flow: in_valid=1, pc=0x0,0x4,0x8,0xC on 4 edges -> edge 4: st_pc[3..0]=0x0,0x4,0x8,0xC, st_valid=4'b1111.
// - Load-use: stall[1]=1 one cycle, full pipe -> in_ready=0, boundaries 0,1 hold, st_valid[2]=0 next edge, st_pc[3] advances.
// - Branch flush: flush=4'b0011 with stall=4'b0001 -> st_valid[1:0]=0, boundary 0 keeps pc, boundary 2 loads old boundary 1.
// - Perf (macro on): 10 cycles, 6 valid retirements, 4 bubbles at MEM/WB -> cycle_cnt=10, retire_cnt=6, bubble_cnt=4;
//   macro off -> all three read 0.
// - Params: NSTG=5, XLEN=64, PAYLOAD_W=128 -> pc 64'hFFFF_FFFF_FFFF_FFFC reaches boundary 4 after 5 edges unaltered.

Source files
------------

// File: rtl/riscv_pipe_regs.sv
// Inter-stage register chain for the pipelined RISC-V core: pc + payload per boundary
// with per-boundary stall/flush and bubble insertion. Optional perf counters: RISCV_PIPE_PERF_CNT_EN.
module riscv_pipe_regs #(
  parameter int NSTG      = 4,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  output logic                      in_ready,
  input  logic [NSTG-1:0]           stall,
  input  logic [NSTG-1:0]           flush,
  output logic [NSTG-1:0]           st_valid,
  output logic [NSTG*XLEN-1:0]      st_pc,
  output logic [NSTG*PAYLOAD_W-1:0] st_payload,
  output logic [31:0]               cycle_cnt,
  output logic [31:0]               retire_cnt,
  output logic [31:0]               bubble_cnt
);

  logic [NSTG-1:0]           hold;
  logic [NSTG-1:0]           prev_hold;
  logic [NSTG-1:0]           src_valid;
  logic [NSTG*XLEN-1:0]      src_pc;
  logic [NSTG*PAYLOAD_W-1:0] src_payload;

  // A stall anywhere downstream freezes every boundary at or upstream of it.
  for (genvar i = 0; i < NSTG; i++) begin : g_hold
    assign hold[i] = |stall[NSTG-1:i];
  end

  assign in_ready    = ~hold[0];
  assign prev_hold   = {hold[NSTG-2:0], 1'b0};
  assign src_valid   = {st_valid[NSTG-2:0], in_valid};
  assign src_pc      = {st_pc[(NSTG-1)*XLEN-1:0], in_pc};
  assign src_payload = {st_payload[(NSTG-1)*PAYLOAD_W-1:0], in_payload};

  // NOTE: payload/pc are cleared on reset too, since their reset value is architecturally visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid   <= '0;
      st_pc      <= '0;
      st_payload <= '0;
    end else begin
      for (int i = 0; i < NSTG; i++) begin
        // NOTE: non-blocking updates let every boundary load its source's pre-edge content.
        if (flush[i]) begin
          st_valid[i] <= 1'b0;
        end else if (!hold[i]) begin
          if (prev_hold[i]) begin
            st_valid[i] <= 1'b0;
          end else begin
            st_valid[i]                        <= src_valid[i];
            st_pc[i*XLEN +: XLEN]              <= src_pc[i*XLEN +: XLEN];
            st_payload[i*PAYLOAD_W +: PAYLOAD_W] <= src_payload[i*PAYLOAD_W +: PAYLOAD_W];
          end
        end
      end
    end
  end

`ifdef RISCV_PIPE_PERF_CNT_EN
  logic retire_en;
  assign retire_en = st_valid[NSTG-1] & ~hold[NSTG-1] & ~flush[NSTG-1];

  // All counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire_en && retire_cnt != 32'hFFFF_FFFF) retire_cnt <= retire_cnt + 32'd1;
      if (!st_valid[NSTG-1] && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_pipe_regs.sv
// Self-checking bench for riscv_pipe_regs: directed scenarios plus randomized
// stall/flush traffic compared against a behavioural pipeline model.
module tb_riscv_pipe_regs;
  localparam int N  = 4;
  localparam int XL = 32;
  localparam int PW = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [XL-1:0]     in_pc = '0;
  logic [PW-1:0]     in_payload = '0;
  logic              in_ready;
  logic [N-1:0]      stall = '0;
  logic [N-1:0]      flush = '0;
  logic [N-1:0]      st_valid;
  logic [N*XL-1:0]   st_pc;
  logic [N*PW-1:0]   st_payload;
  logic [31:0]       cycle_cnt, retire_cnt, bubble_cnt;

  // Second instance with widened parameters
  logic              in_valid5 = 1'b0;
  logic [63:0]       in_pc5 = '0;
  logic [127:0]      in_payload5 = '0;
  logic              in_ready5;
  logic [4:0]        stall5 = '0;
  logic [4:0]        flush5 = '0;
  logic [4:0]        st_valid5;
  logic [5*64-1:0]   st_pc5;
  logic [5*128-1:0]  st_payload5;
  logic [31:0]       cycle_cnt5, retire_cnt5, bubble_cnt5;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Behavioural model state
  logic          m_valid [N];
  logic [XL-1:0] m_pc    [N];
  logic [PW-1:0] m_pl    [N];
  logic [31:0]   m_cyc, m_ret, m_bub;

  riscv_pipe_regs #(.NSTG(N), .XLEN(XL), .PAYLOAD_W(PW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_payload(in_payload),
    .in_ready(in_ready), .stall(stall), .flush(flush), .st_valid(st_valid), .st_pc(st_pc),
    .st_payload(st_payload), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  riscv_pipe_regs #(.NSTG(5), .XLEN(64), .PAYLOAD_W(128)) u_dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid5), .in_pc(in_pc5), .in_payload(in_payload5),
    .in_ready(in_ready5), .stall(stall5), .flush(flush5), .st_valid(st_valid5), .st_pc(st_pc5),
    .st_payload(st_payload5), .cycle_cnt(cycle_cnt5), .retire_cnt(retire_cnt5), .bubble_cnt(bubble_cnt5)
  );

  always #5 clk = ~clk;

  // Highest stalled boundary, -1 when nothing stalls; boundaries at or below it are frozen.
  function automatic int top_stall();
    int t = -1;
    for (int j = 0; j < N; j++) if (stall[j]) t = j;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_pl[i] = '0;
    end
    m_cyc = '0; m_ret = '0; m_bub = '0;
  endtask

  task automatic model_step();
    int t = top_stall();
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (m_valid[N-1] && (N-1 > t) && !flush[N-1] && m_ret != 32'hFFFF_FFFF) m_ret++;
    if (!m_valid[N-1] && m_bub != 32'hFFFF_FFFF) m_bub++;
    // Walk downstream-first so each boundary copies its source's old content.
    for (int i = N-1; i >= 0; i--) begin
      if (flush[i])                 m_valid[i] = 1'b0;
      else if (i <= t)              ;
      else if (i > 0 && i-1 <= t)   m_valid[i] = 1'b0;
      else if (i == 0) begin
        m_valid[0] = in_valid; m_pc[0] = in_pc; m_pl[0] = in_payload;
      end else begin
        m_valid[i] = m_valid[i-1]; m_pc[i] = m_pc[i-1]; m_pl[i] = m_pl[i-1];
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0; stall = '0; flush = '0; in_valid5 = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++; if (st_valid !== '0) $display("FAIL reset_valid: got %b expected 0", st_valid); else pass_cnt++;
    chk_cnt++; if (st_pc !== '0) $display("FAIL reset_pc: got %h expected 0", st_pc); else pass_cnt++;
    chk_cnt++; if (st_payload !== '0) $display("FAIL reset_payload: got %h expected 0", st_payload); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else pass_cnt++;
    chk_cnt++; if ({cycle_cnt, retire_cnt, bubble_cnt} !== '0)
      $display("FAIL reset_counters: got %h/%h/%h expected 0", cycle_cnt, retire_cnt, bubble_cnt); else pass_cnt++;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_straight_flow();
    logic [XL-1:0] exp_pc;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = XL'(4*k); in_payload = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    chk_cnt++; if (st_valid !== 4'b1111) $display("FAIL flow_valid: got %b expected 1111", st_valid); else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      exp_pc = XL'(4*(N-1-i));
      chk_cnt++; if (st_pc[i*XL +: XL] !== exp_pc)
        $display("FAIL flow_pc[%0d]: got %h expected %h", i, st_pc[i*XL +: XL], exp_pc); else pass_cnt++;
      chk_cnt++; if (st_payload[i*PW +: PW] !== m_pl[i])
        $display("FAIL flow_payload[%0d]: got %h expected %h", i, st_payload[i*PW +: PW], m_pl[i]); else pass_cnt++;
    end
  endtask

  task automatic fill_pipe(input logic [XL-1:0] base);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_pc = base + XL'(4*k); in_payload = {$urandom, $urandom};
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [XL-1:0] o_pc0, o_pc1, o_pc2;
    fill_pipe(32'h100);
    in_pc = 32'h200; in_payload = {$urandom, $urandom};
    stall = 4'b0010;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL loaduse_ready: got %b expected 0", in_ready); else pass_cnt++;
    o_pc0 = m_pc[0]; o_pc1 = m_pc[1]; o_pc2 = m_pc[2];
    tick();
    stall = '0;
    chk_cnt++; if (st_pc[0 +: XL] !== o_pc0) $display("FAIL loaduse_hold0: got %h expected %h", st_pc[0 +: XL], o_pc0); else pass_cnt++;
    chk_cnt++; if (st_pc[XL +: XL] !== o_pc1) $display("FAIL loaduse_hold1: got %h expected %h", st_pc[XL +: XL], o_pc1); else pass_cnt++;
    chk_cnt++; if (st_valid !== 4'b1011) $display("FAIL loaduse_valid: got %b expected 1011", st_valid); else pass_cnt++;
    chk_cnt++; if (st_pc[3*XL +: XL] !== o_pc2) $display("FAIL loaduse_adv3: got %h expected %h", st_pc[3*XL +: XL], o_pc2); else pass_cnt++;
  endtask

  task automatic test_branch_flush();
    logic [XL-1:0] o_pc0, o_pc1;
    stall = '0; flush = '0;
    fill_pipe(32'h300);
    in_pc = 32'h400;
    stall = 4'b0001; flush = 4'b0011;
    o_pc0 = m_pc[0]; o_pc1 = m_pc[1];
    tick();
    stall = '0; flush = '0;
    chk_cnt++; if (st_valid !== 4'b1100) $display("FAIL flush_valid: got %b expected 1100", st_valid); else pass_cnt++;
    chk_cnt++; if (st_pc[0 +: XL] !== o_pc0) $display("FAIL flush_keep0: got %h expected %h", st_pc[0 +: XL], o_pc0); else pass_cnt++;
    chk_cnt++; if (st_pc[2*XL +: XL] !== o_pc1) $display("FAIL flush_load2: got %h expected %h", st_pc[2*XL +: XL], o_pc1); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_pc = 32'h500 + XL'(4*k); in_payload = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    chk_cnt++; if (st_valid !== 4'b0111) $display("FAIL mid_prefill: got %b expected 0111", st_valid); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++; if (st_valid !== '0) $display("FAIL mid_reset_valid: got %b expected 0", st_valid); else pass_cnt++;
    chk_cnt++; if (st_pc !== '0) $display("FAIL mid_reset_pc: got %h expected 0", st_pc); else pass_cnt++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_pc = 32'h600 + XL'(4*k); in_payload = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
`ifdef RISCV_PIPE_PERF_CNT_EN
    chk_cnt++; if (cycle_cnt !== 32'd10) $display("FAIL perf_cycle: got %0d expected 10", cycle_cnt); else pass_cnt++;
    chk_cnt++; if (retire_cnt !== 32'd6) $display("FAIL perf_retire: got %0d expected 6", retire_cnt); else pass_cnt++;
    chk_cnt++; if (bubble_cnt !== 32'd4) $display("FAIL perf_bubble: got %0d expected 4", bubble_cnt); else pass_cnt++;
`else
    chk_cnt++; if ({cycle_cnt, retire_cnt, bubble_cnt} !== '0)
      $display("FAIL perf_off: got %0d/%0d/%0d expected 0", cycle_cnt, retire_cnt, bubble_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic last_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (last_ready) begin
        in_valid = 1'($urandom_range(0, 1)); in_pc = $urandom; in_payload = {$urandom, $urandom};
      end
      for (int j = 0; j < N; j++) begin
        stall[j] = ($urandom_range(0, 7) == 0);
        flush[j] = ($urandom_range(0, 9) == 0);
      end
      last_ready = (top_stall() < 0);
      #1;
      chk_cnt++; if (in_ready !== last_ready)
        $display("FAIL rnd_ready c%0d: got %b expected %b", c, in_ready, last_ready); else pass_cnt++;
      tick();
      for (int i = 0; i < N; i++) begin
        chk_cnt++;
        if (st_valid[i] !== m_valid[i] || st_pc[i*XL +: XL] !== m_pc[i] || st_payload[i*PW +: PW] !== m_pl[i])
          $display("FAIL rnd_stage%0d c%0d: got v=%b pc=%h pl=%h expected v=%b pc=%h pl=%h", i, c,
                   st_valid[i], st_pc[i*XL +: XL], st_payload[i*PW +: PW], m_valid[i], m_pc[i], m_pl[i]);
        else pass_cnt++;
      end
`ifdef RISCV_PIPE_PERF_CNT_EN
      chk_cnt++; if (cycle_cnt !== m_cyc || retire_cnt !== m_ret || bubble_cnt !== m_bub)
        $display("FAIL rnd_counters c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                 cycle_cnt, retire_cnt, bubble_cnt, m_cyc, m_ret, m_bub); else pass_cnt++;
`else
      chk_cnt++; if ({cycle_cnt, retire_cnt, bubble_cnt} !== '0)
        $display("FAIL rnd_counters_off c%0d: got %0d/%0d/%0d expected 0", c, cycle_cnt, retire_cnt, bubble_cnt);
      else pass_cnt++;
`endif
    end
    stall = '0; flush = '0; in_valid = 1'b0;
  endtask

  task automatic test_params();
    logic [63:0]  exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    logic [127:0] exp_pl = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    do_reset();
    in_valid5 = 1'b1; in_pc5 = exp_pc; in_payload5 = exp_pl;
    tick();
    in_valid5 = 1'b0; in_pc5 = '0; in_payload5 = '0;
    for (int k = 0; k < 3; k++) tick();
    chk_cnt++; if (st_valid5 !== 5'b01000) $display("FAIL p5_after4: got %b expected 01000", st_valid5); else pass_cnt++;
    tick();
    chk_cnt++; if (st_valid5 !== 5'b10000) $display("FAIL p5_after5: got %b expected 10000", st_valid5); else pass_cnt++;
    chk_cnt++; if (st_pc5[4*64 +: 64] !== exp_pc) $display("FAIL p5_pc: got %h expected %h", st_pc5[4*64 +: 64], exp_pc); else pass_cnt++;
    chk_cnt++; if (st_payload5[4*128 +: 128] !== exp_pl)
      $display("FAIL p5_payload: got %h expected %h", st_payload5[4*128 +: 128], exp_pl); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_straight_flow();
    test_load_use();
    test_branch_flush();
    test_reset_midstream();
    test_perf();
    test_random();
    test_params();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
